// File: rtl/byte_frame_assembler.sv
// Byte-stream frame assembler: SYNC, length, payload, XOR checksum -> one wide word.
// Optional stall timeout is compiled in with `define BFA_TIMEOUT_EN.
module byte_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 8,
    parameter int         TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 in_valid,
    input  logic [7:0]           in,
    output logic                 out_valid,
    output logic                 out_err,
    output logic [3:0]           out_len,
    output logic [MAX_LEN*8-1:0] out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    state_t               r_state;
    logic [3:0]           r_len;
    logic [3:0]           r_cnt;
    logic [7:0]           r_csum;
    logic [MAX_LEN*8-1:0] r_stage;
    logic                 w_timeout;
    logic                 w_len_ok;

    assign w_len_ok = (in >= 8'd1) && (in <= 8'(MAX_LEN));

`ifdef BFA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;

    assign w_timeout = (r_state != S_IDLE) && (r_tmo == TW'(TIMEOUT));

    // Every state change coincides with a valid byte or a timeout, so those clears cover it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_tmo <= '0;
        end else if (in_valid || w_timeout || (r_state == S_IDLE)) begin
            r_tmo <= '0;
        end else if (r_tmo != TW'(TIMEOUT)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_csum    <= '0;
            r_stage   <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_len   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            if (w_timeout) begin
                out_err <= 1'b1;
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else if (in_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (in == SYNC_BYTE) begin
                            r_state <= S_LEN;
                            busy    <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len   <= in[3:0];
                            r_csum  <= in;
                            r_cnt   <= '0;
                            r_stage <= '0;
                            r_state <= S_PAYLOAD;
                        end else begin
                            out_err <= 1'b1;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    S_PAYLOAD: begin
                        r_stage[8*r_cnt +: 8] <= in;
                        r_csum                <= r_csum ^ in;
                        r_cnt                 <= r_cnt + 4'd1;
                        if ((r_cnt + 4'd1) == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (in == r_csum) begin
                            out_data  <= r_stage;
                            out_len   <= r_len;
                            out_valid <= 1'b1;
                        end else begin
                            out_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_frame_assembler.sv
// Bench for byte_frame_assembler: directed frames plus random frame mixes checked against a frame-level model.
module tb_byte_frame_assembler;

    localparam int         MAX_LEN = 8;
    localparam int         W       = MAX_LEN * 8;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic         clk = 1'b0;
    logic         areset;
    logic         in_valid;
    logic [7:0]   in_b;
    logic         out_valid;
    logic         out_err;
    logic [3:0]   out_len;
    logic [W-1:0] out_data;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic         err;
        logic [3:0]   len;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [3:0]   m_len;
    logic [W-1:0] m_data;

    byte_frame_assembler #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(16)) dut (
        .clk      (clk),
        .areset   (areset),
        .in_valid (in_valid),
        .in       (in_b),
        .out_valid(out_valid),
        .out_err  (out_err),
        .out_len  (out_len),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_b     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Model: computes the expected outcome of a whole frame from the framing rules, then drives it.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[MAX_LEN],
                              input logic bad_csum, input int maxgap);
        exp_t       e;
        logic [7:0] c;
        c = len;
        if (len == 8'd0 || len > 8'(MAX_LEN)) begin
            e.err = 1'b1; e.len = m_len; e.data = m_data;
            exp_q.push_back(e);
            send_byte(SYNC, $urandom_range(0, maxgap));
            send_byte(len, $urandom_range(0, maxgap));
            return;
        end
        e.data = '0;
        for (int i = 0; i < int'(len); i++) begin
            c = c ^ pl[i];
            e.data[8*i +: 8] = pl[i];
        end
        if (bad_csum) begin
            e.err = 1'b1; e.len = m_len; e.data = m_data;
        end else begin
            e.err = 1'b0; e.len = len[3:0];
            m_len = len[3:0]; m_data = e.data;
        end
        exp_q.push_back(e);
        send_byte(SYNC, $urandom_range(0, maxgap));
        send_byte(len, $urandom_range(0, maxgap));
        for (int i = 0; i < int'(len); i++) send_byte(pl[i], $urandom_range(0, maxgap));
        if (bad_csum) c = c ^ 8'($urandom_range(1, 255));
        send_byte(c, $urandom_range(0, maxgap));
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset   = 1'b1;
        in_valid = 1'b0;
        #1;
        m_len  = '0;
        m_data = '0;
        @(negedge clk);
        areset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!areset && (out_valid || out_err)) begin
            exp_t e;
            check_eq("pulse_exclusive", {out_valid, out_err} == 2'b11, 1'b0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {out_valid, out_err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_valid", out_valid, !e.err);
                check_eq("sb_err", out_err, e.err);
                check_eq("sb_len", out_len, e.len);
                check_eq("sb_data", out_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[MAX_LEN];
        logic [7:0] len;
        logic [7:0] g;
        areset = 1'b1; in_valid = 1'b0; in_b = 8'h00;
        m_len = '0; m_data = '0;
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_err", out_err, 1'b0);
        check_eq("rst_len", out_len, 4'd0);
        check_eq("rst_data", out_data, '0);
        check_eq("rst_busy", busy, 1'b0);
        idle(2);
        areset = 1'b0;

        // Good frame with exact pulse timing.
        pl = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(8'd3, pl, 1'b0, 0);
        idle(1);
        check_eq("t1_pulse", out_valid, 1'b1);
        check_eq("t1_data", out_data, 64'h0000_0000_0033_2211);
        idle(1);
        check_eq("t1_pulse_end", out_valid, 1'b0);
        check_eq("t1_idle_busy", busy, 1'b0);

        // Checksum mismatch: data and length must hold.
        pl = '{8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(8'd2, pl, 1'b1, 0);
        idle(3);
        check_eq("t2_len_hold", out_len, 4'd3);

        // Bad lengths.
        send_frame(8'd0, pl, 1'b0, 0);
        idle(2);
        check_eq("t3_busy0", busy, 1'b0);
        send_frame(8'd9, pl, 1'b0, 0);
        idle(2);
        check_eq("t3_busy9", busy, 1'b0);

        // Stalled frame followed back-to-back by a frame carrying SYNC as payload.
        pl = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(8'd1, pl, 1'b0, 3);
        pl[0] = SYNC;
        send_frame(8'd1, pl, 1'b0, 0);
        idle(2);
        check_eq("t4_sync_payload", out_data[7:0], SYNC);

        // Reset mid-frame.
        send_byte(SYNC, 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        #2;
        areset = 1'b1;
        #1;
        check_eq("t5_rst_len", out_len, 4'd0);
        check_eq("t5_rst_data", out_data, '0);
        check_eq("t5_rst_busy", busy, 1'b0);
        m_len = '0; m_data = '0;
        @(negedge clk);
        areset = 1'b0; in_valid = 1'b0;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(8'd4, pl, 1'b0, 1);
        idle(3);
        check_eq("t5_after_len", out_len, 4'd4);

        // Long stall inside a frame.
`ifdef BFA_TIMEOUT_EN
        begin
            exp_t e;
            e.err = 1'b1; e.len = m_len; e.data = m_data;
            exp_q.push_back(e);
        end
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        idle(20);
        check_eq("t6_tmo_busy", busy, 1'b0);
`else
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        idle(20);
        check_eq("t6_stall_busy", busy, 1'b1);
        do_reset();
`endif

        // Random frame mix.
        for (int k = 0; k < 80; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'($urandom);
            if (kind == 0) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2));
            end else if (kind == 1) begin
                len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_frame(len, pl, 1'b0, 2);
            end else begin
                len = 8'($urandom_range(1, MAX_LEN));
                send_frame(len, pl, kind == 2, ($urandom_range(0, 1) == 0) ? 0 : 3);
            end
        end
        idle(5);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_frame_assembler.md
Name: byte_frame_assembler

Overview:
- Consumes the registered 8-bit byte stream produced by the upstream 8-bit DFF stage, one candidate byte per clock qualified by in_valid.
- Finds a sync byte, reads a length byte, collects that many payload bytes, and checks a trailing XOR checksum.
- Presents each good frame as one wide word with a single-cycle valid pulse; bad frames produce an error pulse instead.

Parameters:
- SYNC_BYTE, 8'hA5, value that starts a frame
- MAX_LEN, 8, maximum payload length in bytes (1..15)
- TIMEOUT, 16, stall-cycle limit within a frame; used only when BFA_TIMEOUT_EN is defined

Ports:
- clk  input  1  system clock; all state updates on posedge
- areset  input  1  asynchronous, active-high reset
- in_valid  input  1  in carries a valid byte this cycle
- in  input  8  byte from the upstream DFF stage
- out_valid  output  1  one-cycle pulse: good frame complete
- out_err  output  1  one-cycle pulse: frame rejected
- out_len  output  4  payload length of the last good frame
- out_data  output  MAX_LEN*8  payload of the last good frame; byte 0 in bits [7:0]; unused upper bytes are zero
- busy  output  1  high while state is not IDLE

Behaviour:
- Reset (areset=1, asynchronous): state=IDLE, out_valid=0, out_err=0, out_len=0, out_data=0, busy=0, running checksum=0, byte count=0.
- Bytes are sampled only on posedge clk with in_valid=1. Cycles with in_valid=0 stall the FSM with no state change, except for the timeout counter when that feature is enabled.
- IDLE:
  - in==SYNC_BYTE: go to LEN.
  - Any other byte: discard and stay in IDLE.
- LEN:
  - Sampled byte L must satisfy 1 <= L <= MAX_LEN. Then: csum=L, count=0, clear the staging buffer, go to PAYLOAD.
  - L==0 or L>MAX_LEN: pulse out_err, go to IDLE.
- PAYLOAD:
  - Write each byte into staging byte[count]. Update csum ^= byte and count++.
  - When count reaches L, go to CSUM.
  - A SYNC_BYTE value here is ordinary payload data.
- CSUM:
  - Sampled byte == csum: copy staging to out_data, set out_len=L, pulse out_valid.
  - Mismatch: pulse out_err; out_data and out_len keep their previous values.
  - In both cases go to IDLE.
- Outputs are registered. The pulse is high for exactly the one cycle after the edge that sampled the final byte.
- out_data and out_len hold until the next good frame.
- Back-to-back frames: a SYNC_BYTE sampled on the edge right after the checksum edge is accepted, so there is zero idle gap.
- out_valid and out_err are never high in the same cycle.
- busy is a registered decode of state != IDLE.
- areset asserted mid-frame aborts the frame with no pulse. out_data and out_len return to 0.
- Widths:
  - count is 4 bits.
  - L is compared as 8-bit unsigned before being truncated into out_len.

Optional Feature:
- Macro: BFA_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every in_valid=1 cycle and on any state change, and increments on each in_valid=0 cycle while state is LEN, PAYLOAD or CSUM.
  - When the counter reaches TIMEOUT, pulse out_err on the next cycle, go to IDLE and discard the partial frame.
  - A valid byte arriving on the same edge that the counter hits TIMEOUT is ignored, and the timeout wins.
- Undefined: no counter and no timeout; a frame may stall indefinitely.

Test Plan:
- Good frame: in_valid=1 stream A5,03,11,22,33,03 (03^11^22^33=03) -> out_valid for one cycle one clock after the last byte; out_len=3; out_data[23:0]=24'h332211; upper bytes 0; out_err=0.
- Checksum mismatch: A5,02,10,20,00 -> out_err pulse; out_valid=0; out_data and out_len unchanged from the prior frame.
- Bad length: A5,00 -> out_err; A5,09 with MAX_LEN=8 -> out_err; FSM back in IDLE, busy=0.
- Stalls and back-to-back: frame A5,01,7E,7F with in_valid=0 gaps between bytes, immediately followed by A5,01,A5,A4 -> two out_valid pulses; the second has out_data[7:0]=A5, proving sync is treated as payload.
- Reset mid-frame: assert areset after A5,04,01 -> all outputs 0 immediately; the next full valid frame is assembled correctly.
- With BFA_TIMEOUT_EN, TIMEOUT=16: A5,02 then in_valid=0 for 16 cycles -> out_err pulse; busy=0. Without the macro the same stimulus gives no pulse and busy stays 1.
